// File: rtl/i2s_slave_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_slave_port                                                             |
// | I2S slave: oversampled BCLK/LRCLK/SDIN, 24-bit stereo receive deframing,   |
// | 16-bit stereo transmit serialisation, slot-length checking with relock.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2s_slave_port #(
   parameter int SLOT_BITS   = 32,
   parameter int RX_WIDTH    = 24,
   parameter int TX_WIDTH    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                BCLK,
   input  logic                LRCLK,
   input  logic                SDIN,
   output logic                SDOUT,
   input  logic [TX_WIDTH-1:0] tx_left,
   input  logic [TX_WIDTH-1:0] tx_right,
   output logic                tx_ack,
   output logic [RX_WIDTH-1:0] rx_left,
   output logic [RX_WIDTH-1:0] rx_right,
   output logic                rx_valid,
   output logic                locked,
   output logic                frame_err,
   output logic [7:0]          err_count
);

   localparam int                 c_CNT_W     = $clog2(SLOT_BITS + 1);
   localparam logic [c_CNT_W-1:0] c_SLOT_MAX  = c_CNT_W'(SLOT_BITS);
   localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(SLOT_BITS - 1);
   localparam logic [c_CNT_W-1:0] c_RX_LIM    = c_CNT_W'(RX_WIDTH);

   typedef enum logic [0:0] {
      ST_HUNT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   logic [SYNC_STAGES-1:0] r_bclk_sync;
   logic [SYNC_STAGES-1:0] r_lr_sync;
   logic [SYNC_STAGES-1:0] r_sdin_sync;
   logic                   r_bclk_prev;
   logic                   r_lr_prev;
   logic [c_CNT_W-1:0]     r_bit_cnt;
   logic [RX_WIDTH-1:0]    r_rx_shift;
   logic [RX_WIDTH-1:0]    r_left_hold;
   logic [RX_WIDTH-1:0]    r_right_hold;
   logic                   r_left_good;
   logic                   r_frame_done;
   logic                   r_ack_pend;
   logic [TX_WIDTH-1:0]    r_tx_right_hold;
   logic [TX_WIDTH-1:0]    r_tx_shift;
   logic                   r_sdout;
   logic                   r_tx_ack;
   logic [RX_WIDTH-1:0]    r_rx_left;
   logic [RX_WIDTH-1:0]    r_rx_right;
   logic                   r_rx_valid;
   logic                   r_frame_err;
   logic [7:0]             r_err_count;

   logic                   w_bclk;
   logic                   w_lr;
   logic                   w_sdin;
   logic                   w_bclk_rise;
   logic                   w_bclk_fall;
   logic                   w_boundary;
   logic                   w_good;
   logic                   w_enter;
   logic                   w_err;
   logic                   w_left_store;
   logic                   w_frame_done;
   logic [RX_WIDTH-1:0]    w_rx_shift_next;

   assign w_bclk      = r_bclk_sync[SYNC_STAGES-1];
   assign w_lr        = r_lr_sync[SYNC_STAGES-1];
   assign w_sdin      = r_sdin_sync[SYNC_STAGES-1];
   assign w_bclk_rise = w_bclk & ~r_bclk_prev;
   assign w_bclk_fall = ~w_bclk & r_bclk_prev;

   // r_bit_cnt is the index of the bit carried by the current rise
   assign w_boundary = w_bclk_rise && (w_lr != r_lr_prev);
   assign w_good     = (r_bit_cnt == c_SLOT_LAST);
   assign w_enter    = w_boundary && !w_lr;
   assign w_rx_shift_next = (r_bit_cnt < c_RX_LIM) ?
                            {r_rx_shift[RX_WIDTH-2:0], w_sdin} : r_rx_shift;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_bclk_sync <= '0;
         r_lr_sync   <= '0;
         r_sdin_sync <= '0;
         r_bclk_prev <= 1'b0;
      end else begin
         r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], BCLK};
         r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], LRCLK};
         r_sdin_sync <= {r_sdin_sync[SYNC_STAGES-2:0], SDIN};
         r_bclk_prev <= w_bclk;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= ST_HUNT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A bad lr==0 boundary drops to HUNT and re-enters RUN on the same edge
   always_comb begin
      w_state_next = r_state;
      w_err        = 1'b0;
      w_left_store = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         ST_HUNT: begin
            if (w_enter) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_boundary) begin
               if (!w_good) begin
                  w_err        = 1'b1;
                  w_state_next = w_lr ? ST_HUNT : ST_RUN;
               end else if (w_lr) begin
                  w_left_store = 1'b1;
               end else if (r_left_good) begin
                  w_frame_done = 1'b1;
               end
            end
         end
         default: w_state_next = ST_HUNT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_lr_prev       <= 1'b0;
         r_bit_cnt       <= '0;
         r_rx_shift      <= '0;
         r_left_hold     <= '0;
         r_right_hold    <= '0;
         r_left_good     <= 1'b0;
         r_frame_done    <= 1'b0;
         r_ack_pend      <= 1'b0;
         r_tx_right_hold <= '0;
         r_tx_shift      <= '0;
         r_sdout         <= 1'b0;
         r_tx_ack        <= 1'b0;
         r_rx_left       <= '0;
         r_rx_right      <= '0;
         r_rx_valid      <= 1'b0;
         r_frame_err     <= 1'b0;
         r_err_count     <= '0;
      end else begin
         r_frame_done <= w_frame_done;
         r_ack_pend   <= w_enter;
         r_rx_valid   <= r_frame_done;
         r_tx_ack     <= r_ack_pend;
         r_frame_err  <= w_err;
         if (r_frame_done) begin
            r_rx_left  <= r_left_hold;
            r_rx_right <= r_right_hold;
         end
         if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
         if (w_bclk_rise) begin
            r_lr_prev  <= w_lr;
            r_rx_shift <= w_rx_shift_next;
            if (w_boundary) begin
               r_bit_cnt <= '0;
            end else if (r_bit_cnt != c_SLOT_MAX) begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            // Slot start: the left word comes straight from the port as it is latched
            if (w_boundary) begin
               r_tx_shift <= w_lr ? r_tx_right_hold : tx_left;
            end
         end
         if (w_left_store) begin
            r_left_hold <= w_rx_shift_next;
         end
         if (w_frame_done) begin
            r_right_hold <= w_rx_shift_next;
         end
         if (w_err || w_enter) begin
            r_left_good <= 1'b0;
         end else if (w_left_store) begin
            r_left_good <= 1'b1;
         end
         if (w_enter) begin
            r_tx_right_hold <= tx_right;
         end
         if (r_state == ST_HUNT) begin
            r_sdout <= 1'b0;
         end else if (w_bclk_fall) begin
            r_sdout <= r_tx_shift[TX_WIDTH-1];
         end
         if (w_bclk_fall) begin
            r_tx_shift <= r_tx_shift << 1;
         end
      end
   end

   assign SDOUT     = r_sdout;
   assign tx_ack    = r_tx_ack;
   assign rx_left   = r_rx_left;
   assign rx_right  = r_rx_right;
   assign rx_valid  = r_rx_valid;
   assign locked    = (r_state == ST_RUN);
   assign frame_err = r_frame_err;
   assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2s_slave_port                                                          |
// | Directed I2S master model driving the slave port with frame vectors.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_i2s_slave_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        BCLK;
   logic        LRCLK;
   logic        SDIN;
   logic        SDOUT;
   logic [15:0] tx_left;
   logic [15:0] tx_right;
   logic        tx_ack;
   logic [23:0] rx_left;
   logic [23:0] rx_right;
   logic        rx_valid;
   logic        locked;
   logic        frame_err;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   i2s_slave_port #(
      .SLOT_BITS   (32),
      .RX_WIDTH    (24),
      .TX_WIDTH    (16),
      .SYNC_STAGES (2)
   ) dut (
      .clock     (clk),
      .reset     (reset),
      .BCLK      (BCLK),
      .LRCLK     (LRCLK),
      .SDIN      (SDIN),
      .SDOUT     (SDOUT),
      .tx_left   (tx_left),
      .tx_right  (tx_right),
      .tx_ack    (tx_ack),
      .rx_left   (rx_left),
      .rx_right  (rx_right),
      .rx_valid  (rx_valid),
      .locked    (locked),
      .frame_err (frame_err),
      .err_count (err_count)
   );

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      int          lbits;
      int          rbits;
      logic [15:0] txl;
      logic [15:0] txr;
      int          exp_valid;
      int          exp_err;
      bit          chk_tx;
      bit          exp_unlock;
   } vec_t;

   vec_t vecs [9];
   vec_t v;

   int   n_vec  = 0;
   int   n_miss = 0;

   // Output event monitor, sampled on the falling clock edge
   int   n_valid = 0, n_wide = 0, n_errp = 0, n_ack = 0, n_unlock = 0;
   logic prev_valid = 1'b0;
   time  t_valid = 0, t_rise = 0;

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         n_valid++;
         t_valid = $time;
         if (prev_valid === 1'b1) n_wide++;
      end
      prev_valid = rx_valid;
      if (frame_err === 1'b1) n_errp++;
      if (tx_ack === 1'b1) n_ack++;
      if (locked !== 1'b1) n_unlock++;
   end

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One BCLK period: LRCLK/SDIN change on the fall, SDOUT sampled at the rise
   task automatic bit_cycle(input logic lr, input logic d, output logic so);
      @(negedge clk);
      BCLK = 1'b0; LRCLK = lr; SDIN = d;
      repeat (3) @(negedge clk);
      @(negedge clk);
      so = SDOUT;
      BCLK = 1'b1;
      t_rise = $time;
      repeat (3) @(negedge clk);
   endtask

   // Last bit of a slot already carries the next slot's LRCLK (one-bit delay)
   task automatic send_slot(input logic lr_this, input logic lr_next, input logic [23:0] data,
                            input int nbits, output logic [31:0] cap);
      logic so;
      logic d;
      cap = '0;
      for (int j = 0; j < nbits; j++) begin
         d = (j < 24) ? data[23-j] : 1'b0;
         bit_cycle((j == nbits - 1) ? lr_next : lr_this, d, so);
         if (j < 32) cap[31-j] = so;
      end
   endtask

   initial begin
      logic [31:0] capl, capr;
      logic        so;
      logic [23:0] mr_l;
      int          v0, e0, a0, u0;
      int          exp_err_total;

      vecs[0] = '{24'h800001, 24'h7FFFFE, 32, 32, 16'hA5C3, 16'h0001, 1, 0, 1'b1, 1'b0};
      vecs[1] = '{24'h123456, 24'hABCDEF, 32, 32, 16'hFFFF, 16'h8000, 1, 0, 1'b1, 1'b0};
      vecs[2] = '{24'h000000, 24'hFFFFFF, 32, 32, 16'h0000, 16'h7FFF, 1, 0, 1'b1, 1'b0};
      vecs[3] = '{24'h111111, 24'h222222, 32, 31, 16'h1234, 16'h5678, 0, 1, 1'b0, 1'b0};
      vecs[4] = '{24'h5A5A5A, 24'hA5A5A5, 32, 32, 16'hC3C3, 16'h3C3C, 1, 0, 1'b1, 1'b0};
      vecs[5] = '{24'h333333, 24'h444444, 31, 32, 16'h0F0F, 16'hF0F0, 0, 1, 1'b0, 1'b1};
      vecs[6] = '{24'h0F0F0F, 24'hF0F0F0, 32, 32, 16'h8001, 16'h4002, 1, 0, 1'b1, 1'b0};
      vecs[7] = '{24'h555555, 24'h666666, 32, 33, 16'h2222, 16'h3333, 0, 1, 1'b0, 1'b0};
      vecs[8] = '{24'hC00003, 24'h3FFFFC, 32, 32, 16'hBEEF, 16'h0102, 1, 0, 1'b1, 1'b0};

      // Reset held with BCLK toggling
      reset = 1'b0; BCLK = 1'b0; LRCLK = 1'b1; SDIN = 1'b0;
      tx_left = vecs[0].txl; tx_right = vecs[0].txr;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k % 2 == 1) BCLK = ~BCLK;
      end
      chk("reset_sdout",     SDOUT,     0);
      chk("reset_tx_ack",    tx_ack,    0);
      chk("reset_rx_left",   rx_left,   0);
      chk("reset_rx_right",  rx_right,  0);
      chk("reset_rx_valid",  rx_valid,  0);
      chk("reset_locked",    locked,    0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_err_count", err_count, 0);
      reset = 1'b1;

      // An lr==1 boundary must not lock
      bit_cycle(1'b1, 1'b0, so);
      bit_cycle(1'b1, 1'b0, so);
      repeat (6) @(negedge clk);
      chk("hunt_no_lock_lr1", locked, 0);

      send_slot(1'b1, 1'b0, 24'h0, 32, capr);
      repeat (8) @(negedge clk);
      chk("lock_after_left_start", locked, 1);

      exp_err_total = 0;
      for (int i = 0; i < 9; i++) begin
         v  = vecs[i];
         v0 = n_valid; e0 = n_errp; a0 = n_ack; u0 = n_unlock;
         send_slot(1'b0, 1'b1, v.l, v.lbits, capl);
         if (i < 8) begin
            tx_left  = vecs[i+1].txl;
            tx_right = vecs[i+1].txr;
         end
         send_slot(1'b1, 1'b0, v.r, v.rbits, capr);
         repeat (8) @(negedge clk);
         exp_err_total += v.exp_err;
         chk($sformatf("v%0d_valid_pulses", i), n_valid - v0, v.exp_valid);
         chk($sformatf("v%0d_frame_err_pulses", i), n_errp - e0, v.exp_err);
         chk($sformatf("v%0d_err_count", i), err_count, exp_err_total);
         chk($sformatf("v%0d_tx_ack_pulses", i), n_ack - a0, 1);
         chk($sformatf("v%0d_unlocked", i), (n_unlock - u0) != 0, v.exp_unlock);
         chk($sformatf("v%0d_locked_end", i), locked, 1);
         if (v.exp_valid != 0) begin
            chk($sformatf("v%0d_rx_left", i), rx_left, v.l);
            chk($sformatf("v%0d_rx_right", i), rx_right, v.r);
            chk($sformatf("v%0d_valid_latency", i), (t_valid - t_rise) / 10, 4);
         end
         if (v.chk_tx) begin
            chk($sformatf("v%0d_sdout_left", i), capl, {v.txl, 16'h0000});
            chk($sformatf("v%0d_sdout_right", i), capr, {v.txr, 16'h0000});
         end
      end
      chk("rx_valid_single_cycle", n_wide, 0);

      // Reset for one clock in the middle of a left slot
      mr_l = 24'h6C3A95;
      v0 = n_valid;
      for (int j = 0; j < 10; j++) bit_cycle(1'b0, mr_l[23-j], so);
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      chk("midrst_locked",    locked,    0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_rx_left",   rx_left,   0);
      chk("midrst_rx_right",  rx_right,  0);
      for (int j = 10; j < 32; j++) bit_cycle((j == 31) ? 1'b1 : 1'b0, (j < 24) ? mr_l[23-j] : 1'b0, so);
      send_slot(1'b1, 1'b0, 24'h13579B, 32, capr);
      repeat (8) @(negedge clk);
      chk("midrst_no_valid_partial", n_valid - v0, 0);
      chk("midrst_relocked", locked, 1);
      v0 = n_valid;
      send_slot(1'b0, 1'b1, 24'hFEDCBA, 32, capl);
      send_slot(1'b1, 1'b0, 24'h010203, 32, capr);
      repeat (8) @(negedge clk);
      chk("midrst_valid_full", n_valid - v0, 1);
      chk("midrst_rx_left_full", rx_left, 24'hFEDCBA);
      chk("midrst_rx_right_full", rx_right, 24'h010203);

      // 300 two-bit left slots, each a length error
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      e0 = n_errp;
      send_slot(1'b1, 1'b0, 24'h0, 2, capr);
      for (int k = 0; k < 300; k++) begin
         send_slot(1'b0, 1'b1, 24'h0, 2, capl);
         send_slot(1'b1, 1'b0, 24'h0, 2, capr);
      end
      repeat (8) @(negedge clk);
      chk("sat_err_count", err_count, 8'd255);
      chk("sat_frame_err_pulses", n_errp - e0, 300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
